// File: rtl/dram_ch_arbiter.sv
// dram_ch_arbiter: round-robin arbiter for NUM_CH capture write channels, plus a
// credit-limited read-back engine, in front of a MIG app interface.
// Optional build macro: DRAM_ARB_WRAP_STOP_EN. When it is defined, a channel stops
// capturing after its region wraps once (one-shot capture).
module dram_ch_arbiter #(
    parameter int NUM_CH            = 4,
    parameter int APP_ADDR_WIDTH    = 28,
    parameter int APP_DATA_WIDTH    = 128,
    parameter int APP_MASK_WIDTH    = 16,
    parameter int REGION_ADDR_WIDTH = 20,
    parameter int BURST_STEP        = 8,
    parameter int RD_CREDITS        = 8
) (
    input  logic                              clk,
    input  logic                              i_rst,
    input  logic [NUM_CH-1:0]                 i_wr_valid,
    input  logic [NUM_CH*APP_DATA_WIDTH-1:0]  i_wr_data,
    output logic [NUM_CH-1:0]                 o_wr_ready,
    input  logic                              i_rd_req,
    input  logic [$clog2(NUM_CH)-1:0]         i_rd_ch,
    input  logic [REGION_ADDR_WIDTH-1:0]      i_rd_offset,
    input  logic [15:0]                       i_rd_len,
    output logic                              o_rd_busy,
    output logic                              o_rd_done,
    output logic [APP_DATA_WIDTH-1:0]         o_rd_data,
    output logic                              o_rd_valid,
    input  logic                              i_rd_pop,
    output logic                              o_dram_wen,
    output logic                              o_dram_ren,
    output logic [APP_ADDR_WIDTH-2:0]         o_dram_addr,
    output logic [APP_DATA_WIDTH-1:0]         o_dram_data,
    output logic [APP_MASK_WIDTH-1:0]         o_dram_mask,
    input  logic                              i_dram_ready,
    input  logic                              i_dram_wdf_ready,
    input  logic                              i_dram_data_valid,
    input  logic                              i_init_calib_complete,
    input  logic [APP_DATA_WIDTH-1:0]         i_dram_data,
    output logic [NUM_CH-1:0]                 o_wrapped
);
    localparam int CW = $clog2(NUM_CH);
    localparam int AW = APP_ADDR_WIDTH - 1;
    localparam int RW = REGION_ADDR_WIDTH;
    localparam int OW = $clog2(RD_CREDITS + 1);

    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_RD   = 2'd2;

    logic [1:0]                     state;
    logic [NUM_CH-1:0][RW-1:0]      wptr;
    logic [NUM_CH-1:0]              wrapped;
    logic [CW-1:0]                  rr_ptr;
    logic [CW-1:0]                  rd_ch;
    logic [RW-1:0]                  rptr;
    logic [15:0]                    rd_len;
    logic [15:0]                    issued;
    logic [15:0]                    received;
    logic [OW-1:0]                  outstanding;
    logic                           rd_first;

    logic [NUM_CH-1:0][APP_DATA_WIDTH-1:0] wr_slices;
    logic [NUM_CH-1:0]              wr_elig;
    logic [CW-1:0]                  gnt;
    logic                           gnt_found;
    logic                           active, in_rd, wr_can, rd_can, wr_go, rd_go, pop_eff;
    logic [RW-1:0]                  wptr_nxt;

    assign wr_slices = i_wr_data;
    // Reset forces every output low, even before the first reset edge lands.
    assign active    = ~i_rst;
    assign in_rd     = active && (state == S_RD);

`ifdef DRAM_ARB_WRAP_STOP_EN
    assign wr_elig = i_wr_valid & ~wrapped;
`else
    assign wr_elig = i_wr_valid;
`endif

    // Round-robin search: first eligible channel at or after rr_ptr.
    always_comb begin
        gnt       = rr_ptr;
        gnt_found = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (wr_elig[(int'(rr_ptr) + k) % NUM_CH]) begin
                gnt       = CW'((int'(rr_ptr) + k) % NUM_CH);
                gnt_found = 1'b1;
            end
        end
    end

    assign wr_can   = active && (state != S_INIT) && gnt_found && i_dram_ready && i_dram_wdf_ready;
    assign rd_can   = in_rd && (issued < rd_len) && (outstanding < OW'(RD_CREDITS)) && i_dram_ready;
    // On a tie the read wins when rd_first is set; rd_first flips after each tie.
    assign rd_go    = rd_can && (!wr_can || rd_first);
    assign wr_go    = wr_can && !rd_go;
    assign pop_eff  = i_rd_pop && (outstanding != '0);
    assign wptr_nxt = wptr[gnt] + RW'(BURST_STEP);

    assign o_dram_wen  = wr_go;
    assign o_dram_ren  = rd_go;
    assign o_wr_ready  = wr_go ? (NUM_CH'(1) << gnt) : '0;
    assign o_dram_addr = wr_go ? AW'({gnt, wptr[gnt]}) : (rd_go ? AW'({rd_ch, rptr}) : '0);
    assign o_dram_data = wr_go ? wr_slices[gnt] : '0;
    assign o_dram_mask = '0;
    assign o_rd_valid  = in_rd && i_dram_data_valid;
    assign o_rd_data   = in_rd ? i_dram_data : '0;
    assign o_rd_busy   = in_rd;
    assign o_rd_done   = in_rd && i_init_calib_complete && (received == rd_len);
    assign o_wrapped   = active ? wrapped : '0;

    // State, pointers, credits and the read-job FSM.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state       <= S_INIT;
            wptr        <= '0;
            wrapped     <= '0;
            rr_ptr      <= '0;
            rd_ch       <= '0;
            rptr        <= '0;
            rd_len      <= '0;
            issued      <= '0;
            received    <= '0;
            outstanding <= '0;
            rd_first    <= 1'b1;
        end else begin
            if (wr_go) begin
                wptr[gnt] <= wptr_nxt;
                if (wptr_nxt == '0)
                    wrapped[gnt] <= 1'b1;
                rr_ptr <= (gnt == CW'(NUM_CH - 1)) ? '0 : gnt + 1'b1;
            end
            if (rd_go) begin
                rptr   <= rptr + RW'(BURST_STEP);
                issued <= issued + 16'd1;
            end
            if (rd_go && !pop_eff)
                outstanding <= outstanding + 1'b1;
            else if (!rd_go && pop_eff)
                outstanding <= outstanding - 1'b1;
            if (wr_can && rd_can)
                rd_first <= ~rd_first;
            if (state == S_RD && i_dram_data_valid)
                received <= received + 16'd1;

            if (!i_init_calib_complete) begin
                state <= S_INIT;
            end else begin
                case (state)
                    S_INIT: state <= S_RUN;
                    S_RUN: if (i_rd_req) begin
                        rd_ch    <= i_rd_ch;
                        rptr     <= i_rd_offset;
                        rd_len   <= i_rd_len;
                        issued   <= '0;
                        received <= '0;
                        rd_first <= 1'b1;
                        state    <= S_RD;
                    end
                    S_RD: if (received == rd_len) state <= S_RUN;
                    default: state <= S_INIT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dram_ch_arbiter.sv
// Bench for dram_ch_arbiter: randomized stimulus checked every cycle against a
// behavioural model, plus directed scenarios pinned by hand-computed values.
module tb_dram_ch_arbiter;
    localparam int NCH = 4, AAW = 28, DW = 128, MW = 16, RAW = 6, BS = 8, CR = 8;
    localparam int REG = 1 << RAW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              i_rst, i_rd_req, i_rd_pop, i_dram_ready, i_dram_wdf_ready;
    logic              i_dram_data_valid, i_init_calib_complete;
    logic [NCH-1:0]    i_wr_valid, o_wr_ready, o_wrapped;
    logic [NCH*DW-1:0] i_wr_data;
    logic [1:0]        i_rd_ch;
    logic [RAW-1:0]    i_rd_offset;
    logic [15:0]       i_rd_len;
    logic              o_rd_busy, o_rd_done, o_rd_valid, o_dram_wen, o_dram_ren;
    logic [DW-1:0]     o_rd_data, o_dram_data, i_dram_data;
    logic [AAW-2:0]    o_dram_addr;
    logic [MW-1:0]     o_dram_mask;

    dram_ch_arbiter #(.NUM_CH(NCH), .APP_ADDR_WIDTH(AAW), .APP_DATA_WIDTH(DW),
        .APP_MASK_WIDTH(MW), .REGION_ADDR_WIDTH(RAW), .BURST_STEP(BS), .RD_CREDITS(CR)) dut (
        .clk(clk), .i_rst(i_rst), .i_wr_valid(i_wr_valid), .i_wr_data(i_wr_data),
        .o_wr_ready(o_wr_ready), .i_rd_req(i_rd_req), .i_rd_ch(i_rd_ch),
        .i_rd_offset(i_rd_offset), .i_rd_len(i_rd_len), .o_rd_busy(o_rd_busy),
        .o_rd_done(o_rd_done), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
        .i_rd_pop(i_rd_pop), .o_dram_wen(o_dram_wen), .o_dram_ren(o_dram_ren),
        .o_dram_addr(o_dram_addr), .o_dram_data(o_dram_data), .o_dram_mask(o_dram_mask),
        .i_dram_ready(i_dram_ready), .i_dram_wdf_ready(i_dram_wdf_ready),
        .i_dram_data_valid(i_dram_data_valid), .i_init_calib_complete(i_init_calib_complete),
        .i_dram_data(i_dram_data), .o_wrapped(o_wrapped));

    int n_cmp = 0, n_fail = 0;

    // Behavioural model: mode 0 = waiting for calibration, 1 = idle, 2 = read job.
    int mode, rr, mch, mrp, mlen, miss, mrcv, mout;
    int wp[NCH];
    bit [NCH-1:0] mwrap;
    bit mprio;

    // Observation logs used by the directed checks.
    int wlog_ch[$], wlog_addr[$], rlog_addr[$], kinds[$];
    int ren_cnt = 0, done_cnt = 0, rv_cnt = 0, beats_sent = 0;
    bit resp_en = 1'b0;

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, a, e);
        end
    endtask

    task automatic model_step();
        bit act, found, wc, rc, rgo, wgo, inrd, fin, pe;
        bit [NCH-1:0] elig;
        int g, e_addr;
        logic [DW-1:0] e_data;
        act = !i_rst;
`ifdef DRAM_ARB_WRAP_STOP_EN
        elig = i_wr_valid & ~mwrap;
`else
        elig = i_wr_valid;
`endif
        g = 0; found = 0;
        for (int k = 0; k < NCH; k++)
            if (!found && elig[(rr + k) % NCH]) begin g = (rr + k) % NCH; found = 1; end
        wc   = act && mode != 0 && found && i_dram_ready && i_dram_wdf_ready;
        rc   = act && mode == 2 && miss < mlen && mout < CR && i_dram_ready;
        rgo  = rc && (!wc || mprio);
        wgo  = wc && !rgo;
        inrd = act && mode == 2;
        fin  = (mrcv == mlen);
        e_addr = wgo ? g * REG + wp[g] : (rgo ? mch * REG + mrp : 0);
        e_data = wgo ? i_wr_data[g*DW +: DW] : '0;
        chk("wen", o_dram_wen, wgo);
        chk("ren", o_dram_ren, rgo);
        chk("wr_ready", o_wr_ready, wgo ? (1 << g) : 0);
        chk("addr", o_dram_addr, e_addr);
        chk("wdata", o_dram_data, e_data);
        chk("mask", o_dram_mask, 0);
        chk("rd_valid", o_rd_valid, inrd && i_dram_data_valid);
        chk("rd_data", o_rd_data, inrd ? i_dram_data : '0);
        chk("busy", o_rd_busy, inrd);
        chk("done", o_rd_done, inrd && i_init_calib_complete && fin);
        chk("wrapped", o_wrapped, act ? mwrap : '0);
        // logs from the DUT side, pinned later against literals
        if (o_dram_wen) begin
            for (int k = 0; k < NCH; k++) if (o_wr_ready[k]) wlog_ch.push_back(k);
            wlog_addr.push_back(int'(o_dram_addr));
            kinds.push_back(2);
        end
        if (o_dram_ren) begin
            ren_cnt++;
            rlog_addr.push_back(int'(o_dram_addr));
            kinds.push_back(1);
        end
        if (o_rd_done) done_cnt++;
        if (o_rd_valid) rv_cnt++;
        // advance to the next clock edge
        if (i_rst) begin
            mode = 0; rr = 0; mch = 0; mrp = 0; mlen = 0; miss = 0; mrcv = 0; mout = 0;
            mwrap = '0; mprio = 1;
            for (int k = 0; k < NCH; k++) wp[k] = 0;
        end else begin
            pe = i_rd_pop && mout > 0;
            if (wgo) begin
                wp[g] = (wp[g] + BS) % REG;
                if (wp[g] == 0) mwrap[g] = 1;
                rr = (g + 1) % NCH;
            end
            if (rgo) begin mrp = (mrp + BS) % REG; miss++; end
            mout = mout + (rgo ? 1 : 0) - (pe ? 1 : 0);
            if (wc && rc) mprio = !mprio;
            if (mode == 2 && i_dram_data_valid) mrcv++;
            if (!i_init_calib_complete) mode = 0;
            else if (mode == 0) mode = 1;
            else if (mode == 1) begin
                if (i_rd_req) begin
                    mch = int'(i_rd_ch); mrp = int'(i_rd_offset); mlen = int'(i_rd_len);
                    miss = 0; mrcv = 0; mprio = 1; mode = 2;
                end
            end else if (fin) mode = 1;
        end
    endtask

    // One clock: responder drives a return beat, compare at negedge, inputs change after posedge.
    task automatic cycle();
        if (resp_en && ren_cnt > beats_sent && $urandom_range(0, 3) != 0) begin
            i_dram_data_valid = 1'b1;
            beats_sent++;
        end else i_dram_data_valid = 1'b0;
        i_dram_data = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1; cycle();
        i_rst = 1'b0; cycle();
        beats_sent = ren_cnt;
    endtask

    initial begin
        int r0, d0, v0;
        i_rst = 1'b1; i_rd_req = 0; i_rd_pop = 0; i_dram_ready = 0; i_dram_wdf_ready = 0;
        i_dram_data_valid = 0; i_init_calib_complete = 0; i_wr_valid = '0;
        i_rd_ch = '0; i_rd_offset = '0; i_rd_len = '0; i_dram_data = '0;
        for (int k = 0; k < NCH; k++) i_wr_data[k*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
        mode = 0; rr = 0; mout = 0; mwrap = '0; mprio = 1; mlen = 0; mrcv = 0; miss = 0;
        mch = 0; mrp = 0;
        for (int k = 0; k < NCH; k++) wp[k] = 0;
        repeat (3) cycle();
        chk("reset_wrapped", o_wrapped, 0);
        chk("reset_busy", o_rd_busy, 0);

        // Round-robin over all four channels
        i_rst = 1'b0; i_init_calib_complete = 1'b1;
        cycle();
        i_wr_valid = 4'hF; i_dram_ready = 1; i_dram_wdf_ready = 1;
        wlog_ch.delete(); wlog_addr.delete();
        repeat (5) cycle();
        chk("rr_count", wlog_ch.size(), 5);
        for (int k = 0; k < 5; k++) begin
            chk("rr_grant", wlog_ch[k], k % 4);
            chk("rr_addr", wlog_addr[k], (k == 4) ? 32'h08 : k * 32'h40);
        end

        // Region wrap on channel 1
        i_wr_valid = '0;
        do_reset();
        i_wr_valid = 4'b0010;
        wlog_addr.delete();
        repeat (10) cycle();
        chk("wrap_8th", wlog_addr[7], 32'h78);
        chk("wrap_flag", o_wrapped, 4'b0010);
`ifdef DRAM_ARB_WRAP_STOP_EN
        chk("wrap_count", wlog_addr.size(), 8);
        chk("wrap_stop_ready", o_wr_ready[1], 0);
`else
        chk("wrap_count", wlog_addr.size(), 10);
        chk("wrap_next", wlog_addr[8], 32'h40);
`endif

        // Credit-limited read job: ch2, offset 0x10, len 20
        i_wr_valid = '0;
        do_reset();
        resp_en = 1;
        rlog_addr.delete();
        r0 = ren_cnt; d0 = done_cnt; v0 = rv_cnt;
        i_rd_req = 1; i_rd_ch = 2; i_rd_offset = 6'h10; i_rd_len = 16'd20;
        cycle();
        i_rd_req = 0;
        repeat (30) cycle();
        chk("credit_stall", ren_cnt - r0, 8);
        chk("rd_addr0", rlog_addr[0], 32'h90);
        chk("rd_addr1", rlog_addr[1], 32'h98);
        chk("rd_addr6_wrap", rlog_addr[6], 32'h80);
        i_rd_pop = 1;
        repeat (12) cycle();
        i_rd_pop = 0;
        for (int t = 0; t < 300 && done_cnt == d0; t++) cycle();
        chk("rd_done_seen", done_cnt != d0, 1);
        repeat (5) cycle();
        chk("rd_done_once", done_cnt - d0, 1);
        chk("rd_issued", ren_cnt - r0, 20);
        chk("rd_beats", rv_cnt - v0, 20);

        // Write/read alternation
        do_reset();
        i_wr_valid = 4'b0001; i_rd_pop = 1;
        d0 = done_cnt;
        i_rd_req = 1; i_rd_ch = 1; i_rd_offset = 0; i_rd_len = 16'd16;
        cycle();
        i_rd_req = 0;
        kinds.delete();
        repeat (8) cycle();
        for (int k = 0; k < 8; k++) chk("alternate", kinds[k], (k % 2 == 0) ? 1 : 2);
        for (int t = 0; t < 300 && done_cnt == d0; t++) cycle();
        chk("alt_done", done_cnt - d0, 1);

        // Abort by calibration loss
        i_wr_valid = '0; i_rd_pop = 0;
        i_rd_req = 1; i_rd_ch = 3; i_rd_offset = 0; i_rd_len = 16'd20;
        cycle();
        i_rd_req = 0;
        repeat (5) cycle();
        d0 = done_cnt;
        i_init_calib_complete = 0;
        cycle();
        chk("calib_abort_busy", o_rd_busy, 0);
        i_init_calib_complete = 1;
        repeat (2) cycle();
        chk("calib_abort_done", done_cnt - d0, 0);

        // Abort by reset
        i_rd_pop = 1; repeat (10) cycle(); i_rd_pop = 0;
        i_rd_req = 1; i_rd_len = 16'd20;
        cycle();
        i_rd_req = 0;
        repeat (4) cycle();
        d0 = done_cnt;
        i_rst = 1; cycle();
        i_rst = 0;
        chk("rst_abort_busy", o_rd_busy, 0);
        repeat (3) cycle();
        chk("rst_abort_done", done_cnt - d0, 0);

        // Randomized traffic against the model
        for (int t = 0; t < 3000; t++) begin
            i_rst = ($urandom_range(0, 599) == 0);
            i_init_calib_complete = ($urandom_range(0, 399) != 0);
            i_wr_valid = NCH'($urandom);
            i_dram_ready = ($urandom_range(0, 4) != 0);
            i_dram_wdf_ready = ($urandom_range(0, 5) != 0);
            i_rd_req = ($urandom_range(0, 15) == 0);
            i_rd_ch = 2'($urandom);
            i_rd_offset = RAW'($urandom);
            i_rd_len = 16'($urandom_range(0, 24));
            i_rd_pop = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0)
                for (int k = 0; k < NCH; k++) i_wr_data[k*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/dram_ch_arbiter.md
DRAM_CH_ARBITER -- requirements
Module: dram_ch_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of capture write channels, 2..8.
REQ-002 SHALL have parameter APP_ADDR_WIDTH, default 28: MIG app address width; the block drives bits [APP_ADDR_WIDTH-2:0].
REQ-003 SHALL have parameter APP_DATA_WIDTH, default 128, and APP_MASK_WIDTH, default 16: MIG app data and mask widths.
REQ-004 SHALL have parameter REGION_ADDR_WIDTH, default 20: per-channel region size in app address units; NUM_CH*2^REGION_ADDR_WIDTH <= 2^(APP_ADDR_WIDTH-1).
REQ-005 SHALL have parameter BURST_STEP, default 8: address increment per command.
REQ-006 SHALL have parameter RD_CREDITS, default 8: maximum unpopped read beats.
REQ-007 SHALL have ports clk in 1 (MIG UI clock) and i_rst in 1; one clock; reset is synchronous and active-high.
REQ-008 SHALL have ports i_wr_valid in NUM_CH, i_wr_data in NUM_CH*APP_DATA_WIDTH (channel n at slice n), and o_wr_ready out NUM_CH.
REQ-009 SHALL have ports i_rd_req in 1, i_rd_ch in clog2(NUM_CH), i_rd_offset in REGION_ADDR_WIDTH, i_rd_len in 16 (beats), o_rd_busy out 1, and o_rd_done out 1.
REQ-010 SHALL have ports o_rd_data out APP_DATA_WIDTH, o_rd_valid out 1, and i_rd_pop in 1 (downstream buffer pop, returns one credit).
REQ-011 SHALL have ports o_dram_wen, o_dram_ren out 1; o_dram_addr out APP_ADDR_WIDTH-1; o_dram_data out APP_DATA_WIDTH; o_dram_mask out APP_MASK_WIDTH.
REQ-012 SHALL have ports i_dram_ready, i_dram_wdf_ready, i_dram_data_valid, i_init_calib_complete in 1; i_dram_data in APP_DATA_WIDTH; o_wrapped out NUM_CH (sticky per-channel wrap flags).

Function
REQ-013 SHALL implement FSM S_INIT -> S_RUN on i_init_calib_complete=1; S_RUN -> S_RD on i_rd_req; S_RD -> S_RUN when the job completes; any state -> S_INIT on i_init_calib_complete=0, aborting any job without o_rd_done.
REQ-014 SHALL choose write grant g by round-robin over channels with i_wr_valid=1, starting after the last granted channel; the pointer advances only on an issued write.
REQ-015 SHALL issue a write when not in S_INIT, i_wr_valid[g]=1, i_dram_ready=1, i_dram_wdf_ready=1, and the read slot is not taken (REQ-019); in that same cycle o_dram_wen=1 and o_wr_ready[g]=1 (zero-latency handshake), with all other o_wr_ready bits 0.
REQ-016 SHALL drive, on a write, o_dram_addr = {g, wptr[g]} zero-extended and o_dram_data = slice g; o_dram_mask SHALL be constant 0.
REQ-017 SHALL advance wptr[g] by BURST_STEP modulo 2^REGION_ADDR_WIDTH after each write; on wrap to 0 it SHALL set o_wrapped[g].
REQ-018 SHALL latch i_rd_ch, i_rd_offset and i_rd_len on i_rd_req in S_RUN and assert o_rd_busy through S_RD; i_rd_req in any other state SHALL be ignored.
REQ-019 SHALL issue a read in S_RD when issued < len, outstanding < RD_CREDITS, and i_dram_ready=1, using address {ch, rptr}; rptr wraps within the region like wptr.
REQ-020 SHALL alternate priority when a write and a read are both eligible in S_RD (first tie goes to read); only one of o_dram_wen and o_dram_ren SHALL be high per cycle.
REQ-021 SHALL increment outstanding on a read issue and decrement it on i_rd_pop; both in the same cycle SHALL leave it unchanged; i_rd_pop at 0 SHALL be ignored.
REQ-022 SHALL pass i_dram_data/i_dram_data_valid combinationally to o_rd_data/o_rd_valid only in S_RD; beats outside S_RD SHALL be dropped.
REQ-023 SHALL complete a job when received == len: one-cycle o_rd_done, then S_RUN; len=0 SHALL complete on the cycle after entry.

Reset
REQ-024 On i_rst=1 at a clk edge the block SHALL enter S_INIT with all wptr, rptr, counters, o_wrapped and the RR pointer (channel 0) cleared; all outputs SHALL be 0 during and after reset until the FSM leaves S_INIT.
REQ-025 Reset mid-job SHALL abort the job with no o_rd_done.

Configuration
REQ-026 With DRAM_ARB_WRAP_STOP_EN defined, a channel with o_wrapped set SHALL be excluded from arbitration and its o_wr_ready held 0 until reset (one-shot capture); without it, channels overwrite their region indefinitely.

Verification
REQ-027 NUM_CH=4, all i_wr_valid=1, ready high -> grants 0,1,2,3,0; addresses 0x000000, 0x100000, 0x200000, 0x300000, 0x000008.
REQ-028 REGION_ADDR_WIDTH=6, ch1 writes 8 times -> 8th address 0x78, next 0x40, o_wrapped=4'b0010; with DRAM_ARB_WRAP_STOP_EN, ch1 o_wr_ready stays 0 afterward.
REQ-029 Read ch2, offset 0x10, len 20, RD_CREDITS=8, no i_rd_pop -> exactly 8 o_dram_ren, then stall; 12 pops -> remaining 12 issued; o_rd_done once, after beat 20.
REQ-030 Write on ch0 and read job both eligible continuously -> o_dram_ren, o_dram_wen alternate; never both high.
REQ-031 i_init_calib_complete dropped mid-job, or i_rst=1 mid-job -> no o_rd_done, o_rd_busy=0 next cycle, S_INIT.
